// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO. Occupancy is held in a registered
//   counter, and the status flags are decoded from that counter. Rejected
//   requests raise a one-cycle overflow/underflow pulse. A write to a full
//   FIFO is accepted when a read is accepted in the same cycle.
//
//   Optional feature: define SYNC_FIFO_FWFT_EN for first-word-fall-through
//   reads. In that mode rd_data shows the head word combinationally. Without
//   it, rd_data is registered and updates on each accepted read.
//
// Parameters
//   DATA_WIDTH  width of each stored word
//   ADDR_WIDTH  depth = 2**ADDR_WIDTH words (2..10)
//   AF_THRESH   almost_full  when count >= AF_THRESH (1..depth)
//   AE_THRESH   almost_empty when count <= AE_THRESH (0..depth-1)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   wr_en         write request
//   wr_data       write word
//   rd_en         read request (pop in FWFT mode)
//   rd_data       read word
//   count         words stored, 0..depth
//   full, empty   count == depth, count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A read frees a slot in the same cycle, so a full FIFO can still take
    // a write when a read is accepted alongside it.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Flags come from the registered count only. They never come from the
    // current request inputs.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // NOTE: the storage array has no reset. Its contents are only
    // observable behind a valid pointer, and leaving it out of the reset
    // lets it map onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values that were present before the edge.
    // This is what lets a read and a write to the same slot in one cycle
    // see the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly. It is meaningless while empty.
    assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_acc) begin
            rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Directed bench for sync_fifo_param (8-bit words, depth 8, AF=6, AE=1).
//   Inputs change 1 ns after the rising edge, and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fails  = 0;

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every output against its reset value.
    task automatic check_reset(input string tag);
        check({tag, " count"},     32'(count), 32'd0);
        check({tag, " empty"},     32'(empty), 32'd1);
        check({tag, " a_empty"},   32'(almost_empty), 32'd1);
        check({tag, " full"},      32'(full), 32'd0);
        check({tag, " a_full"},    32'(almost_full), 32'd0);
        check({tag, " overflow"},  32'(overflow), 32'd0);
        check({tag, " underflow"}, 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check({tag, " rd_data"},   32'(rd_data), 32'd0);
`endif
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pop one word and check it. This also completes any write the caller
    // has already set up for the same cycle.
    task automatic pop(input string tag, input logic [7:0] exp_d, input logic [3:0] exp_cnt);
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, " head"}, 32'(rd_data), 32'(exp_d));
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
        check({tag, " rd_data"}, 32'(rd_data), 32'(exp_d));
`endif
        check({tag, " count"}, 32'(count), 32'(exp_cnt));
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        #2;
        check_reset("reset");
        tick();
        rst = 1'b0;

        // Fill with 0x11..0x88. almost_full appears at 6, and full at 8.
        for (int i = 0; i < 8; i++) begin
            push(8'((i + 1) * 8'h11));
            check($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
            check($sformatf("fill%0d full", i), 32'(full), 32'(i == 7));
            check($sformatf("fill%0d a_full", i), 32'(almost_full), 32'(i >= 5));
            check($sformatf("fill%0d a_empty", i), 32'(almost_empty), 32'(i == 0));
        end

        // Write to a full FIFO with no read: it is rejected.
        push(8'hEE);
        check("ovf pulse", 32'(overflow), 32'd1);
        check("ovf count", 32'(count), 32'd8);
        tick();
        check("ovf clears", 32'(overflow), 32'd0);

        // Write and read together on a full FIFO: both are accepted.
        wr_en   = 1'b1;
        wr_data = 8'h99;
        pop("full rw", 8'h11, 4'd8);
        check("full rw ovf", 32'(overflow), 32'd0);
        check("full rw udf", 32'(underflow), 32'd0);

        // Drain. 0xEE must not appear, and 0x99 comes last.
        for (int i = 1; i < 8; i++) begin
            pop($sformatf("drain%0d", i), 8'((i + 1) * 8'h11), 4'(8 - i));
        end
        pop("drain 99", 8'h99, 4'd0);
        check("drained empty", 32'(empty), 32'd1);

        // Read from an empty FIFO.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf pulse", 32'(underflow), 32'd1);
        check("udf count", 32'(count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("udf rd_data hold", 32'(rd_data), 32'h99);
`endif
        tick();
        check("udf clears", 32'(underflow), 32'd0);

        // Read and write together on an empty FIFO: only the write lands.
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("empty rw udf", 32'(underflow), 32'd1);
        check("empty rw count", 32'(count), 32'd1);
        pop("empty rw", 8'hA5, 4'd0);
        check("empty rw udf clr", 32'(underflow), 32'd0);

        // Twenty write/read pairs. The pointers wrap past depth 8 twice.
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h40 + i));
            check($sformatf("pair%0d count", i), 32'(count), 32'd1);
            pop($sformatf("pair%0d", i), 8'(8'h40 + i), 4'd0);
        end

`ifdef SYNC_FIFO_FWFT_EN
        // The head word falls through without any rd_en.
        push(8'h3C);
        check("fwft head", 32'(rd_data), 32'h3C);
        pop("fwft pop", 8'h3C, 4'd0);
`endif

        // Reset with five words stored. The response must not wait for clk.
        for (int i = 0; i < 5; i++) begin
            push(8'(8'hC0 + i));
        end
        check("pre-rst count", 32'(count), 32'd5);
        rst = 1'b1;
        #1;
        check_reset("mid rst");
        rst = 1'b0;
        tick();
        check_reset("post rst");

        // The contents are discarded. The next word is the only one present.
        push(8'h5A);
        check("post rst count", 32'(count), 32'd1);
        pop("post rst", 8'h5A, 4'd0);
        check("post rst empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
